// File: rtl/sram_lsu_port.sv
// -----------------------------------------------------------------------------
// sram_lsu_port
//
// Initiator-side controller between a core load/store unit and a single-port,
// 32-bit, byte-masked SRAM with a registered read address.  One request is
// accepted at a time over a valid/ready channel and exactly one response is
// returned over a second valid/ready channel.
//
// Stores are issued combinationally in the accept cycle, so the SRAM commits
// them at the accept edge.  Loads present the word address in the accept
// cycle.  The read word is captured one cycle later, lane-shifted and then
// sign- or zero-extended.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/ready request handshake (ready only while idle)
//   req_addr        byte address
//   req_wen         1 = store, 0 = load
//   req_size        0 byte, 1 halfword, 2/3 word
//   req_unsigned    loads: 1 zero-extend, 0 sign-extend
//   req_wdata       right-aligned store data
//   rsp_valid/ready response handshake
//   rsp_rdata       extended load data (0 for stores and errors)
//   rsp_err         misaligned request flag
//   sram_din/addr/we/wem  SRAM write data, word index, strobe, byte mask
//   sram_dout       SRAM read data (registered-address read)
//
// Build option
//   SRAM_LSU_PORT_MISALIGN_CHK_EN  when defined, misaligned halfword/word
//   requests are rejected with rsp_err = 1 and no SRAM write.  When undefined,
//   the low address bits are ignored for those sizes and rsp_err stays 0.
// -----------------------------------------------------------------------------
module sram_lsu_port #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int MW = DW / 8
) (
   input  logic          clk,
   input  logic          rst_n,
   // request channel
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic          req_wen,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [DW-1:0] req_wdata,
   // response channel
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   // SRAM pins
   output logic [DW-1:0] sram_din,
   output logic [AW-1:0] sram_addr,
   output logic          sram_we,
   output logic [MW-1:0] sram_wem,
   input  logic [DW-1:0] sram_dout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_RSP  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;     // last accepted word index
   logic [1:0]    lane_q, lane_d;     // effective byte lane of the load
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   logic       size_byte, size_half;
   logic [1:0] eff_lane;
   logic       misalign;
   logic       accept;
   logic       drive;
   logic       do_write;

   assign size_byte = (req_size == 2'd0);
   assign size_half = (req_size == 2'd1);

   // Halfwords use only addr[1] and words always start at lane 0.  For aligned
   // requests this equals addr[1:0].  Without the check it forces the aligned
   // lane.
   always_comb begin
      if (size_byte)      eff_lane = req_addr[1:0];
      else if (size_half) eff_lane = {req_addr[1], 1'b0};
      else                eff_lane = 2'b00;
   end

`ifdef SRAM_LSU_PORT_MISALIGN_CHK_EN
   assign misalign = (size_half && req_addr[0]) ||
                     (!size_byte && !size_half && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign accept   = req_valid && (state_q == S_IDLE);
   // The SRAM pins are driven from the request combinationally.  Gating with
   // rst_n keeps a request presented during reset from writing the memory.
   assign drive    = accept && rst_n;
   assign do_write = drive && req_wen && !misalign;

   // ---------------------------------------------------------------------------
   // SRAM pin drive
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      sram_we   = 1'b0;
      sram_wem  = '0;
      sram_din  = '0;
      sram_addr = addr_q;
      if (drive) begin
         sram_addr = req_addr >> 2;
      end
      if (do_write) begin
         sram_we = 1'b1;
         if (size_byte) begin
            sram_din = {4{req_wdata[7:0]}};
            sram_wem = MW'(4'b0001) << eff_lane;
         end else if (size_half) begin
            sram_din = {2{req_wdata[15:0]}};
            sram_wem = MW'(4'b0011) << eff_lane;
         end else begin
            sram_din = req_wdata;
            sram_wem = '1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Load lane selection and extension
   // ---------------------------------------------------------------------------
   logic [DW-1:0] shifted;
   logic [DW-1:0] load_ext;

   assign shifted = sram_dout >> {lane_q, 3'b000};

   always_comb begin
      load_ext = shifted;
      case (size_q)
         2'd0: load_ext = uns_q ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
         2'd1: load_ext = uns_q ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM next state and response datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lane_d  = lane_q;
      size_d  = size_q;
      uns_d   = uns_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d  = req_addr >> 2;
               lane_d  = eff_lane;
               size_d  = req_size;
               uns_d   = req_unsigned;
               rdata_d = '0;
               err_d   = misalign;
               // Errors and stores answer immediately.  Loads wait one cycle
               // for the SRAM read data.
               if (misalign || req_wen) state_d = S_RSP;
               else                     state_d = S_RD;
            end
         end
         S_RD: begin
            rdata_d = load_ext;
            state_d = S_RSP;
         end
         S_RSP: begin
            // Response registers are left untouched here so they stay stable
            // until the handshake.
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         lane_q  <= 2'b00;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lane_q  <= lane_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RSP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_sram_lsu_port.sv
// -----------------------------------------------------------------------------
// tb_sram_lsu_port
//
// Directed bench for sram_lsu_port with a behavioural byte-masked SRAM that has
// a registered read address.  Expected responses are queued when a request is
// accepted and compared when the response handshake happens.
// -----------------------------------------------------------------------------
module tb_sram_lsu_port;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic          req_wen = 1'b0;
   logic [1:0]    req_size = 2'd0;
   logic          req_unsigned = 1'b0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic [DW-1:0] sram_din;
   logic [AW-1:0] sram_addr;
   logic          sram_we;
   logic [MW-1:0] sram_wem;
   logic [DW-1:0] sram_dout;

   always #5 clk = ~clk;

   sram_lsu_port #(.AW(AW), .DW(DW), .MW(MW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_wen      (req_wen),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .sram_din     (sram_din),
      .sram_addr    (sram_addr),
      .sram_we      (sram_we),
      .sram_wem     (sram_wem),
      .sram_dout    (sram_dout)
   );

   // ---------------------------------------------------------------------------
   // SRAM model: masked write at the edge, registered read address
   // ---------------------------------------------------------------------------
   logic [31:0]   mem [256];
   logic [AW-1:0] rd_addr_q = '0;
   int            we_count = 0;

   always @(posedge clk) begin
      if (sram_we === 1'b1) begin
         for (int b = 0; b < MW; b++)
            if (sram_wem[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_din[8*b +: 8];
         we_count <= we_count + 1;
      end
      rd_addr_q <= sram_addr;
   end

   assign sram_dout = mem[rd_addr_q[7:0]];

   // ---------------------------------------------------------------------------
   // Scoreboard and checking
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   logic          acc_we;
   logic [MW-1:0] acc_wem;
   logic [DW-1:0] acc_din;
   logic [AW-1:0] acc_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Presents a request, waits (bounded) for acceptance, records the SRAM pins
   // of the accept cycle and queues the expected response.
   task automatic send(input string tag, input logic [31:0] addr, input logic wen,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
      int n = 0;
      req_valid    = 1'b1;
      req_addr     = addr;
      req_wen      = wen;
      req_size     = size;
      req_unsigned = uns;
      req_wdata    = wdata;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      check({tag, " accept"}, {31'b0, req_ready}, 32'd1);
      acc_we   = sram_we;
      acc_wem  = sram_wem;
      acc_din  = sram_din;
      acc_addr = sram_addr;
      sb_q.push_back('{rdata: exp_rdata, err: exp_err});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wen   = 1'b0;
   endtask

   // Waits (bounded) for a response, checks latency when exp_lat > 0, compares
   // against the scoreboard and completes the handshake.
   task automatic get_rsp(input string tag, input int exp_lat);
      int   n;
      rsp_t e;
      @(negedge clk);
      n = 1;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
      if (exp_lat > 0) check({tag, " latency"}, 32'(n), 32'(exp_lat));
      check({tag, " sb_nonempty"}, {31'b0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) e = sb_q.pop_front();
      else                  e = '0;
      check({tag, " rdata"}, rsp_rdata, e.rdata);
      check({tag, " err"}, {31'b0, rsp_err}, {31'b0, e.err});
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int we_before;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst req_ready", {31'b0, req_ready}, 32'd1);
      check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst rsp_rdata", rsp_rdata, 32'h0);
      check("rst rsp_err",   {31'b0, rsp_err}, 32'd0);
      check("rst sram_we",   {31'b0, sram_we}, 32'd0);
      check("rst sram_wem",  {28'b0, sram_wem}, 32'h0);
      check("rst sram_din",  sram_din, 32'h0);
      check("rst sram_addr", sram_addr, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post-rst req_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Word store / load at 0x10
      send("st_w", 32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
      check("st_w we",   {31'b0, acc_we}, 32'd1);
      check("st_w wem",  {28'b0, acc_wem}, 32'hF);
      check("st_w addr", acc_addr, 32'd4);
      check("st_w din",  acc_din, 32'hDEADBEEF);
      get_rsp("st_w", 1);
      send("ld_w", 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
      check("ld_w we",   {31'b0, acc_we}, 32'd0);
      check("ld_w addr", acc_addr, 32'd4);
      get_rsp("ld_w", 2);

      // Byte store at 0x13, signed and unsigned byte loads
      send("st_b", 32'h13, 1'b1, 2'd0, 1'b0, 32'h00000080, 32'h0, 1'b0);
      check("st_b wem", {28'b0, acc_wem}, 32'h8);
      check("st_b din", acc_din, 32'h80808080);
      get_rsp("st_b", 1);
      send("ld_bs", 32'h13, 1'b0, 2'd0, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
      get_rsp("ld_bs", 2);
      send("ld_bu", 32'h13, 1'b0, 2'd0, 1'b1, 32'h0, 32'h00000080, 1'b0);
      get_rsp("ld_bu", 2);

      // Halfword store at 0x22 over a known word, neighbours untouched
      send("st_w20", 32'h20, 1'b1, 2'd2, 1'b0, 32'h11223344, 32'h0, 1'b0);
      get_rsp("st_w20", 1);
      send("st_h", 32'h22, 1'b1, 2'd1, 1'b0, 32'h00008001, 32'h0, 1'b0);
      check("st_h wem", {28'b0, acc_wem}, 32'hC);
      check("st_h din", acc_din, 32'h80018001);
      get_rsp("st_h", 1);
      send("ld_hs", 32'h22, 1'b0, 2'd1, 1'b0, 32'h0, 32'hFFFF8001, 1'b0);
      get_rsp("ld_hs", 2);
      send("ld_hu20", 32'h20, 1'b0, 2'd1, 1'b1, 32'h0, 32'h00003344, 1'b0);
      get_rsp("ld_hu20", 2);
      send("ld_sz3", 32'h20, 1'b0, 2'd3, 1'b0, 32'h0, 32'h80013344, 1'b0);
      get_rsp("ld_sz3", 2);

      // Backpressure: response held for 5 cycles, competing request ignored
      send("hold", 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);
      @(negedge clk);
      we_before    = we_count;
      req_valid    = 1'b1;
      req_wen      = 1'b1;
      req_addr     = 32'h40;
      req_size     = 2'd2;
      req_wdata    = 32'h12345678;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold rsp_valid", {31'b0, rsp_valid}, 32'd1);
         check("hold rsp_rdata", rsp_rdata, 32'h80ADBEEF);
         check("hold req_ready", {31'b0, req_ready}, 32'd0);
      end
      check("hold no write", 32'(we_count), 32'(we_before));
      req_valid = 1'b0;
      req_wen   = 1'b0;
      get_rsp("hold", 0);

      // Reset in the middle of a load drops the pending response
      send("rst_ld", 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("midrst req_ready", {31'b0, req_ready}, 32'd1);
      sb_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("postrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1;

      // Misaligned word store at 0x11
      we_before = we_count;
`ifdef SRAM_LSU_PORT_MISALIGN_CHK_EN
      send("mis", 32'h11, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1);
      check("mis we", {31'b0, acc_we}, 32'd0);
      get_rsp("mis", 1);
      check("mis no write", 32'(we_count), 32'(we_before));
      send("mis_ld", 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);
      get_rsp("mis_ld", 2);
`else
      send("mis", 32'h11, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
      check("mis we",   {31'b0, acc_we}, 32'd1);
      check("mis wem",  {28'b0, acc_wem}, 32'hF);
      check("mis addr", acc_addr, 32'd4);
      get_rsp("mis", 1);
      check("mis one write", 32'(we_count), 32'(we_before + 1));
      send("mis_ld", 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
      get_rsp("mis_ld", 2);
`endif

      check("sb drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
